// File: rtl/soc_bus_pkg.sv
// Shared types and address-map constants for the sonar channel bus front-end.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [3:0]  USER_BASE_NIB = 4'h3;
  localparam int unsigned ERR_WORD      = 0;
  localparam int unsigned RSVD_WORD     = 1;
  localparam int unsigned CH_WORD_BASE  = 2;
  localparam int unsigned REGS_PER_CH   = 16;
  localparam int unsigned REG_W         = $clog2(REGS_PER_CH);
  localparam int unsigned CH_DW         = 16;
  localparam int unsigned WORD_W        = 9;
  localparam int unsigned CH_IDX_W      = WORD_W - REG_W;

endpackage

// File: rtl/soc_addr_dec.sv
// Combinational decode of a WB access into ERR / reserved / channel register targets.
module soc_addr_dec
  import soc_bus_pkg::*;
#(
  parameter int unsigned N_CH = 12
) (
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic [31:0]         adr_i,
  output logic                hit_o,
  output logic                is_err_o,
  output logic                is_rsvd_o,
  output logic                oob_o,
  output logic [CH_IDX_W-1:0] ch_idx_o,
  output logic [REG_W-1:0]    reg_idx_o
);

  localparam int unsigned CMP_W = CH_IDX_W + 1;

  logic [WORD_W-1:0] word_c;
  logic [WORD_W-1:0] rel_c;
  logic              unused_c;

  assign word_c    = adr_i[10:2];
  assign rel_c     = word_c - WORD_W'(CH_WORD_BASE);
  assign hit_o     = cyc_i & stb_i & (adr_i[31:28] == USER_BASE_NIB);
  assign is_err_o  = (word_c == WORD_W'(ERR_WORD));
  assign is_rsvd_o = (word_c == WORD_W'(RSVD_WORD));
  assign ch_idx_o  = rel_c[WORD_W-1:REG_W];
  assign reg_idx_o = rel_c[REG_W-1:0];
  // Channel index is meaningless for the two low words, so they never count as out of range.
  assign oob_o     = ~is_err_o & ~is_rsvd_o & (CMP_W'(ch_idx_o) >= CMP_W'(N_CH));

  assign unused_c  = ^{adr_i[27:11], adr_i[1:0]};

endmodule

// File: rtl/soc_bus_ctrl.sv
// Wishbone slave sharing one user-area port among N_CH sonar channels,
// with per-channel request timeout, sticky W1C error flags and an error interrupt.
module soc_bus_ctrl
  import soc_bus_pkg::*;
#(
  parameter int unsigned N_CH    = 12,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [N_CH-1:0]       ch_valid_o,
  output logic [REG_W-1:0]      ch_adr_o,
  output logic [CH_DW-1:0]      ch_dat_o,
  output logic                  ch_strb_o,
  input  logic [N_CH-1:0]       ch_ack_i,
  input  logic [CH_DW*N_CH-1:0] ch_dat_i,
  output logic                  irq_o
);

  state_e state_q, state_d;

  logic                hit_c, is_err_c, is_rsvd_c, oob_c;
  logic [CH_IDX_W-1:0] ch_idx_c;
  logic [REG_W-1:0]    reg_idx_c;

  logic [N_CH-1:0]  ch_valid_q, ch_valid_d;
  logic [REG_W-1:0] ch_adr_q, ch_adr_d;
  logic [CH_DW-1:0] ch_dat_q, ch_dat_d;
  logic             ch_strb_q, ch_strb_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [N_CH-1:0]  err_q, err_d, err_set_c, err_clr_c;
  logic             oob_q, oob_d, oob_set_c, oob_clr_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;

  logic [N_CH-1:0]  sel_oh_c;
  logic [CH_DW-1:0] ch_rd_c;
  logic [31:0]      err_rd_c;
  logic             live_c, start_c, ch_ack_c, timeout_c, unused_c;

  soc_addr_dec #(.N_CH(N_CH)) u_dec (
    .cyc_i     (wbs_cyc_i),
    .stb_i     (wbs_stb_i),
    .adr_i     (wbs_adr_i),
    .hit_o     (hit_c),
    .is_err_o  (is_err_c),
    .is_rsvd_o (is_rsvd_c),
    .oob_o     (oob_c),
    .ch_idx_o  (ch_idx_c),
    .reg_idx_o (reg_idx_c)
  );

  // The cycle showing ack still carries the finished request, so it must not restart one.
  assign live_c    = wbs_cyc_i & wbs_stb_i;
  assign start_c   = hit_c & ~ack_q;
  assign ch_ack_c  = |(ch_ack_i & ch_valid_q);
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err_rd_c  = 32'(err_q) | {oob_q, 31'b0};
  assign unused_c  = ^{wbs_sel_i[3:1], wbs_dat_i};

  always_comb begin
    sel_oh_c = '0;
    ch_rd_c  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sel_oh_c[k] = (ch_idx_c == CH_IDX_W'(k));
      if (ch_valid_q[k]) ch_rd_c = ch_rd_c | ch_dat_i[k*CH_DW +: CH_DW];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_c) state_d = (is_err_c | is_rsvd_c | oob_c) ? ACK : REQ;
      REQ: begin
        if (!live_c)                     state_d = IDLE;
        else if (ch_ack_c || timeout_c)  state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_valid_d = ch_valid_q;
    ch_adr_d   = ch_adr_q;
    ch_dat_d   = ch_dat_q;
    ch_strb_d  = ch_strb_q;
    ack_d      = (state_q == ACK);
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    err_set_c  = '0;
    err_clr_c  = '0;
    oob_set_c  = 1'b0;
    oob_clr_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          if (is_err_c) begin
            dat_d = err_rd_c;
            if (wbs_we_i && wbs_sel_i[0]) begin
              err_clr_c = wbs_dat_i[N_CH-1:0];
              oob_clr_c = wbs_dat_i[31];
            end
          end else if (is_rsvd_c) begin
            dat_d = '0;
          end else if (oob_c) begin
            dat_d     = '0;
            oob_set_c = 1'b1;
          end else begin
            ch_valid_d = sel_oh_c;
            ch_adr_d   = reg_idx_c;
            ch_dat_d   = {wbs_dat_i[31], wbs_dat_i[14:0]};
            ch_strb_d  = wbs_we_i & wbs_sel_i[0];
            cnt_d      = '0;
          end
        end
      end
      REQ: begin
        // Priority: abort, then channel ack, then timeout.
        if (!live_c) begin
          ch_valid_d = '0;
        end else if (ch_ack_c) begin
          dat_d      = {{(32-CH_DW){ch_rd_c[CH_DW-1]}}, ch_rd_c};
          ch_valid_d = '0;
        end else if (timeout_c) begin
          dat_d      = '1;
          err_set_c  = ch_valid_q;
          ch_valid_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    err_d = (err_q & ~err_clr_c) | err_set_c;
    oob_d = (oob_q & ~oob_clr_c) | oob_set_c;
    irq_d = (|err_d) | oob_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ch_valid_q <= '0;
      ch_adr_q   <= '0;
      ch_dat_q   <= '0;
      ch_strb_q  <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      oob_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ch_valid_q <= ch_valid_d;
      ch_adr_q   <= ch_adr_d;
      ch_dat_q   <= ch_dat_d;
      ch_strb_q  <= ch_strb_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      oob_q      <= oob_d;
      irq_q      <= irq_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign ch_valid_o = ch_valid_q;
  assign ch_adr_o   = ch_adr_q;
  assign ch_dat_o   = ch_dat_q;
  assign ch_strb_o  = ch_strb_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// Scoreboard bench for soc_bus_ctrl: directed WB transfers against a scripted channel responder.
module tb_soc_bus_ctrl;

  localparam int unsigned N_CH    = 12;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned CNT_W   = 8;
  localparam int          BUDGET  = 400;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] m;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cyc, stb, we;
  logic [3:0]           sel;
  logic [31:0]          adr, dat;
  logic                 ack;
  logic [31:0]          rdat;
  logic [N_CH-1:0]      ch_valid;
  logic [3:0]           ch_adr;
  logic [15:0]          ch_dat;
  logic                 ch_strb;
  logic [N_CH-1:0]      ch_ack;
  logic [16*N_CH-1:0]   ch_rdat;
  logic                 irq;

  exp_t                 exp_q[$];
  int                   checks = 0;
  int                   failures = 0;

  logic                 resp_en;
  logic [N_CH-1:0]      resp_oh;
  int                   resp_delay;
  int                   rcnt = 0;
  int                   vcyc = 0;
  logic [N_CH-1:0]      last_valid = '0;
  logic [3:0]           cap_adr = '0;
  logic [15:0]          cap_dat = '0;
  logic                 cap_strb = 1'b0;

  soc_bus_ctrl #(.N_CH(N_CH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .ch_valid_o (ch_valid),
    .ch_adr_o   (ch_adr),
    .ch_dat_o   (ch_dat),
    .ch_strb_o  (ch_strb),
    .ch_ack_i   (ch_ack),
    .ch_dat_i   (ch_rdat),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] m);
    exp_t e;
    e.d = d;
    e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    ch_rdat[16*k +: 16] = v;
  endtask

  task automatic arm(input int k, input int delay);
    resp_oh    = N_CH'(1) << k;
    resp_delay = delay;
    resp_en    = 1'b1;
  endtask

  // n counts clock edges from the one that samples stb up to the one where ack is seen.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, output int n);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = 4'h1; adr = a; dat = d;
    vcyc = 0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!ack && n < BUDGET);
    check("ack_seen", 32'(ack), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Scripted channel: acks the armed channel after resp_delay cycles of valid, and logs valid activity.
  initial begin
    ch_ack = '0;
    forever begin
      @(negedge clk);
      ch_ack = '0;
      if (ch_valid != '0) begin
        vcyc++;
        last_valid = ch_valid;
        cap_adr    = ch_adr;
        cap_dat    = ch_dat;
        cap_strb   = ch_strb;
      end
      if (resp_en && ((ch_valid & resp_oh) != '0)) begin
        rcnt++;
        if (rcnt == resp_delay) ch_ack = resp_oh;
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: every WB ack must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_data", rdat & e.m, e.d & e.m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
    ch_rdat = '0; resp_en = 1'b0; resp_oh = '0; resp_delay = 1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_valid", 32'(ch_valid), 32'd0);
    check("rst_chsig", {11'd0, ch_strb, ch_adr, ch_dat}, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    // Channel 0 register 4 write, channel acks after 3 valid cycles.
    set_ch(0, 16'h7ABC); arm(0, 3);
    push_exp(32'h0000_7ABC, '1);
    xfer(32'h3000_0018, 1'b1, 32'h0000_1234, n);
    check("wr_valid_cycles", 32'(vcyc), 32'd3);
    check("wr_valid_onehot", 32'(last_valid), 32'h001);
    check("wr_ch_adr", 32'(cap_adr), 32'd4);
    check("wr_ch_dat", 32'(cap_dat), 32'h1234);
    check("wr_ch_strb", 32'(cap_strb), 32'd1);

    // Channel 0 register 15 write: bit 31 folds into ch_dat bit 15.
    push_exp(32'h0000_7ABC, '1);
    xfer(32'h3000_0044, 1'b1, 32'h8000_4321, n);
    check("wr15_ch_adr", 32'(cap_adr), 32'hF);
    check("wr15_ch_dat", 32'(cap_dat), 32'hC321);

    // Channel 1 register 0 read, negative data sign-extends.
    set_ch(1, 16'h8001); arm(1, 1);
    push_exp(32'hFFFF_8001, '1);
    xfer(32'h3000_0048, 1'b0, 32'h0, n);
    check("rd1_valid_onehot", 32'(last_valid), 32'h002);
    check("rd1_ch_strb", 32'(cap_strb), 32'd0);

    // Channel 3 never acks: timeout, error flag, interrupt.
    resp_en = 1'b0;
    push_exp(32'hFFFF_FFFF, '1);
    xfer(32'h3000_00C8, 1'b0, 32'h0, n);
    check("to_latency", 32'(n), 32'(TIMEOUT + 2));
    check("to_irq", 32'(irq), 32'd1);
    push_exp(32'h0000_0008, '1);
    xfer(32'h3000_0000, 1'b0, 32'h0, n);
    check("err_rd_latency", 32'(n), 32'd2);
    push_exp(32'h0, 32'h0);
    xfer(32'h3000_0000, 1'b1, 32'h0000_0008, n);
    check("w1c_irq", 32'(irq), 32'd0);
    push_exp(32'h0, '1);
    xfer(32'h3000_0000, 1'b0, 32'h0, n);

    // Channel 12 is beyond N_CH: no channel request, oob flag at bit 31.
    push_exp(32'h0, '1);
    xfer(32'h3000_0308, 1'b0, 32'h0, n);
    check("oob_no_valid", 32'(vcyc), 32'd0);
    check("oob_irq", 32'(irq), 32'd1);
    push_exp(32'h8000_0000, '1);
    xfer(32'h3000_0000, 1'b0, 32'h0, n);
    push_exp(32'h0, 32'h0);
    xfer(32'h3000_0000, 1'b1, 32'h8000_0000, n);
    check("oob_clr_irq", 32'(irq), 32'd0);

    // Reserved word reads zero.
    push_exp(32'h0, '1);
    xfer(32'h3000_0004, 1'b0, 32'h0, n);
    check("rsvd_latency", 32'(n), 32'd2);

    // Abort by dropping stb in REQ, then async reset in REQ.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'h1; adr = 32'h3000_0088;
    repeat (4) @(negedge clk);
    check("abort_valid_on", 32'(ch_valid), 32'h004);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_valid_off", 32'(ch_valid), 32'd0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_valid_on", 32'(ch_valid), 32'h004);
    #2 rst_n = 1'b0;
    #1 check("rst_req_valid_off", 32'(ch_valid), 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'h0, '1);
    xfer(32'h3000_0000, 1'b0, 32'h0, n);
    arm(1, 2);
    push_exp(32'hFFFF_8001, '1);
    xfer(32'h3000_0048, 1'b0, 32'h0, n);

    // Ack arrives on the very cycle the timeout expires: ack wins.
    set_ch(5, 16'h1234); arm(5, TIMEOUT);
    push_exp(32'h0000_1234, '1);
    xfer(32'h3000_0148, 1'b0, 32'h0, n);
    check("tie_irq", 32'(irq), 32'd0);
    push_exp(32'h0, '1);
    xfer(32'h3000_0000, 1'b0, 32'h0, n);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
